// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM PCM packer.
//   - channel-mode encodings driven on cfg_ch_mode_i
//   - ch_count(): number of time-multiplexed channels per frame for a mode
//   - pdm_fifo_entry_t: one FIFO slot (frame-last flag + 32-bit word)
package pdm_pkg;

  localparam logic [1:0] PDM_MODE_1CH     = 2'd0;
  localparam logic [1:0] PDM_MODE_2CH_RF  = 2'd1;
  localparam logic [1:0] PDM_MODE_2CH_SEP = 2'd2;
  localparam logic [1:0] PDM_MODE_4CH     = 2'd3;

  localparam int PDM_SAMPLE_W = 16;
  localparam int PDM_WORD_W   = 32;

  typedef struct packed {
    logic                  last;
    logic [PDM_WORD_W-1:0] word;
  } pdm_fifo_entry_t;

  function automatic logic [2:0] ch_count(input logic [1:0] mode);
    logic [2:0] n;
    case (mode)
      PDM_MODE_1CH:     n = 3'd1;
      PDM_MODE_2CH_RF:  n = 3'd2;
      PDM_MODE_2CH_SEP: n = 3'd2;
      default:          n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pdm_pcm_fifo.sv
// Generic synchronous FIFO with flush.
// Ports:
//   clk_i, rstn_i   clock, asynchronous active-low reset
//   flush_i         empties the FIFO (level 0 next cycle)
//   push_i, wdata_i write request and data; accepted when not full, or when
//                   a pop happens in the same cycle
//   pop_i           read request; ignored while empty
//   rdata_o         head entry; while empty it holds the last entry that
//                   left the FIFO (all zeros after reset)
//   full_o, empty_o status flags
//   level_o         number of stored entries
module pdm_pcm_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == LVL_W'(DEPTH));
  assign level_o = cnt_q;
  assign rdata_o = empty_o ? hold_q : mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // A pop frees the head slot in the same cycle, so a full FIFO can still
  // take a push when it is being read.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;

    // Remember whatever leaves the head so rdata_o stays put once empty.
    if ((do_pop || flush_i) && !empty_o) begin
      hold_d = mem_q[rd_ptr_q];
    end

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + LVL_W'(1);
        2'b01:   cnt_d = cnt_q - LVL_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: rtl/pdm_pcm_packer.sv
// Packs the time-multiplexed 16-bit PCM stream into 32-bit words for the
// uDMA RX channel.
// Ports:
//   clk_i, rstn_i    clock, asynchronous active-low reset
//   cfg_en_i         accept input samples when high
//   cfg_update_i     pulse: latch mode/pack, restart channel tracking,
//                    drop a pending half-word and flush the FIFO
//   cfg_ch_mode_i    0=1ch, 1=2ch RF, 2=2ch separate, 3=4ch
//   cfg_pack_i       1=two samples per word, 0=one sign-extended sample
//   cfg_clr_ovf_i    clears overflow_o
//   pcm_data_i/pcm_valid_i  sample stream
//   data_o/data_valid_o/data_ready_i  word stream to the DMA
//   ch_last_o        head word holds the last channel of a frame
//   fifo_lvl_o       FIFO fill level
//   overflow_o       sticky: a completed word was dropped on a full FIFO
module pdm_pcm_packer
  import pdm_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 cfg_en_i,
  input  logic                 cfg_update_i,
  input  logic [1:0]           cfg_ch_mode_i,
  input  logic                 cfg_pack_i,
  input  logic                 cfg_clr_ovf_i,
  input  logic [15:0]          pcm_data_i,
  input  logic                 pcm_valid_i,
  output logic [31:0]          data_o,
  output logic                 data_valid_o,
  input  logic                 data_ready_i,
  output logic                 ch_last_o,
  output logic [LVL_WIDTH-1:0] fifo_lvl_o,
  output logic                 overflow_o
);

  logic [1:0]      mode_q, mode_d;
  logic            pack_q, pack_d;
  logic [1:0]      ch_q, ch_d;
  logic            par_q, par_d;
  logic [15:0]     half_q, half_d;
  logic            ovf_q, ovf_d;

  logic [2:0]      n_ch;
  logic            accept, is_last, is_even;
  logic            push, pop, full, empty;
  pdm_fifo_entry_t push_entry, head_entry;

  // Active mode/pack only change at cfg_update_i so a frame is never split
  // across two configurations.
  assign n_ch    = ch_count(mode_q);
  assign accept  = cfg_en_i & pcm_valid_i & ~cfg_update_i;
  assign is_last = ({1'b0, ch_q} == (n_ch - 3'd1));
  // In 1ch mode the counter is stuck at 0, so pairing uses its own toggle.
  assign is_even = (n_ch == 3'd1) ? ~par_q : ~ch_q[0];
  assign pop     = data_valid_o & data_ready_i;

  always_comb begin
    mode_d     = mode_q;
    pack_d     = pack_q;
    ch_d       = ch_q;
    par_d      = par_q;
    half_d     = half_q;
    push       = 1'b0;
    push_entry = '0;

    if (cfg_update_i) begin
      mode_d = cfg_ch_mode_i;
      pack_d = cfg_pack_i;
      ch_d   = '0;
      par_d  = 1'b0;
      half_d = '0;
    end else if (accept) begin
      ch_d  = is_last ? 2'd0 : ch_q + 2'd1;
      par_d = ~par_q;
      if (pack_q) begin
        if (is_even) begin
          half_d = pcm_data_i;
        end else begin
          push            = 1'b1;
          push_entry.last = is_last;
          push_entry.word = {pcm_data_i, half_q};
        end
      end else begin
        push            = 1'b1;
        push_entry.last = is_last;
        push_entry.word = {{16{pcm_data_i[15]}}, pcm_data_i};
      end
    end
  end

  // Set has priority over clear.
  assign ovf_d = (push & full & ~pop) | (ovf_q & ~cfg_clr_ovf_i);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mode_q <= PDM_MODE_1CH;
      pack_q <= 1'b0;
      ch_q   <= '0;
      par_q  <= 1'b0;
      half_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      pack_q <= pack_d;
      ch_q   <= ch_d;
      par_q  <= par_d;
      half_q <= half_d;
      ovf_q  <= ovf_d;
    end
  end

  pdm_pcm_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(pdm_fifo_entry_t)),
    .LVL_W (LVL_WIDTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .flush_i (cfg_update_i),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head_entry),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_lvl_o)
  );

  assign data_o       = head_entry.word;
  assign ch_last_o    = head_entry.last;
  assign data_valid_o = ~empty;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_pdm_pcm_packer.sv
module tb_pdm_pcm_packer;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        cfg_en_i, cfg_update_i, cfg_pack_i, cfg_clr_ovf_i;
  logic [1:0]  cfg_ch_mode_i;
  logic [15:0] pcm_data_i;
  logic        pcm_valid_i;
  logic [31:0] data_o;
  logic        data_valid_o, data_ready_i, ch_last_o;
  logic [2:0]  fifo_lvl_o;
  logic        overflow_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] sb[$];

  pdm_pcm_packer #(.FIFO_DEPTH(4)) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .cfg_en_i      (cfg_en_i),
    .cfg_update_i  (cfg_update_i),
    .cfg_ch_mode_i (cfg_ch_mode_i),
    .cfg_pack_i    (cfg_pack_i),
    .cfg_clr_ovf_i (cfg_clr_ovf_i),
    .pcm_data_i    (pcm_data_i),
    .pcm_valid_i   (pcm_valid_i),
    .data_o        (data_o),
    .data_valid_o  (data_valid_o),
    .data_ready_i  (data_ready_i),
    .ch_last_o     (ch_last_o),
    .fifo_lvl_o    (fifo_lvl_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    pcm_data_i  = d;
    pcm_valid_i = 1'b1;
    tick();
    pcm_valid_i = 1'b0;
  endtask

  task automatic update(input logic [1:0] mode, input logic pack);
    cfg_ch_mode_i = mode;
    cfg_pack_i    = pack;
    cfg_update_i  = 1'b1;
    tick();
    cfg_update_i  = 1'b0;
  endtask

  // Word accepted by the consumer at the next rising edge: compare with scoreboard.
  always @(negedge clk_i) begin
    if (rstn_i === 1'b1 && data_valid_o === 1'b1 && data_ready_i === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", {ch_last_o, data_o}, 33'h0);
        n_cmp++;
        n_err++;
        $error("FAIL sb_empty observed=%h expected=none", {ch_last_o, data_o});
      end else begin
        chk("dma_word", {ch_last_o, data_o}, sb.pop_front());
      end
    end
  end

  initial begin
    rstn_i = 1'b0;
    cfg_en_i = 1'b1; cfg_update_i = 1'b0; cfg_pack_i = 1'b0; cfg_clr_ovf_i = 1'b0;
    cfg_ch_mode_i = 2'd0; pcm_data_i = '0; pcm_valid_i = 1'b0; data_ready_i = 1'b0;
    #12;
    chk("rst_data",  {1'b0, data_o}, 33'h0);
    chk("rst_valid", {32'h0, data_valid_o}, 33'h0);
    chk("rst_last",  {32'h0, ch_last_o}, 33'h0);
    chk("rst_lvl",   {30'h0, fifo_lvl_o}, 33'h0);
    chk("rst_ovf",   {32'h0, overflow_o}, 33'h0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    tick();

    // 2ch packed, consumer ready
    data_ready_i = 1'b1;
    update(2'd1, 1'b1);
    sb.push_back({1'b1, 32'h22221111});
    sb.push_back({1'b1, 32'h44443333});
    send(16'h1111);
    chk("pack_no_early_valid", {32'h0, data_valid_o}, 33'h0);
    send(16'h2222);
    chk("pack_latency_valid", {32'h0, data_valid_o}, 33'h1);
    chk("pack_latency_data", {1'b0, data_o}, {1'b0, 32'h22221111});
    send(16'h3333);
    send(16'h4444);
    // enable low: sample ignored, pairing held
    sb.push_back({1'b1, 32'h56781234});
    send(16'h1234);
    cfg_en_i = 1'b0;
    send(16'h9999);
    cfg_en_i = 1'b1;
    send(16'h5678);
    repeat (3) tick();
    chk("t1_sb_drained", 33'(sb.size()), 33'h0);

    // 4ch unpacked, sign extension and frame-last
    update(2'd3, 1'b0);
    sb.push_back({1'b0, 32'hFFFF8001});
    sb.push_back({1'b0, 32'h00000002});
    sb.push_back({1'b0, 32'hFFFFFFFF});
    sb.push_back({1'b1, 32'h00007FFF});
    send(16'h8001); send(16'h0002); send(16'hFFFF); send(16'h7FFF);
    repeat (3) tick();
    chk("t2_sb_drained", 33'(sb.size()), 33'h0);

    // overflow: ready low, five words into a 4-deep FIFO
    data_ready_i = 1'b0;
    update(2'd0, 1'b0);
    for (int i = 1; i <= 4; i++) sb.push_back({1'b1, 32'h00000100 + 32'(i)});
    for (int i = 1; i <= 5; i++) send(16'h0100 + 16'(i));
    chk("ovf_lvl_full", {30'h0, fifo_lvl_o}, 33'd4);
    chk("ovf_set", {32'h0, overflow_o}, 33'h1);
    data_ready_i = 1'b1;
    repeat (5) tick();
    chk("ovf_drain_lvl", {30'h0, fifo_lvl_o}, 33'd0);
    chk("ovf_drain_sb", 33'(sb.size()), 33'h0);
    chk("ovf_sticky", {32'h0, overflow_o}, 33'h1);
    cfg_clr_ovf_i = 1'b1;
    tick();
    cfg_clr_ovf_i = 1'b0;
    chk("ovf_cleared", {32'h0, overflow_o}, 33'h0);

    // full FIFO, push with simultaneous pop
    data_ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) sb.push_back({1'b1, 32'h00000010 + 32'(i)});
    for (int i = 1; i <= 4; i++) send(16'h0010 + 16'(i));
    chk("fp_lvl_full", {30'h0, fifo_lvl_o}, 33'd4);
    data_ready_i = 1'b1;
    send(16'h0015);
    chk("fp_lvl_same", {30'h0, fifo_lvl_o}, 33'd4);
    chk("fp_no_ovf", {32'h0, overflow_o}, 33'h0);
    repeat (6) tick();
    chk("fp_sb_drained", 33'(sb.size()), 33'h0);

    // 1ch packed: update flushes FIFO and drops pending half-word
    data_ready_i = 1'b0;
    update(2'd0, 1'b1);
    send(16'h5555); send(16'h6666);
    chk("fl_lvl_before", {30'h0, fifo_lvl_o}, 33'd1);
    send(16'hAAAA);
    update(2'd0, 1'b1);
    chk("fl_lvl_after", {30'h0, fifo_lvl_o}, 33'd0);
    chk("fl_valid_after", {32'h0, data_valid_o}, 33'h0);
    data_ready_i = 1'b1;
    sb.push_back({1'b1, 32'h00020001});
    send(16'h0001); send(16'h0002);
    repeat (3) tick();
    chk("fl_sb_drained", 33'(sb.size()), 33'h0);
    chk("fl_lvl_end", {30'h0, fifo_lvl_o}, 33'd0);

    // async reset with 3 words queued and a half-word pending
    data_ready_i = 1'b0;
    update(2'd1, 1'b1);
    for (int i = 0; i < 7; i++) send(16'hC000 + 16'(i));
    chk("pre_rst_lvl", {30'h0, fifo_lvl_o}, 33'd3);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("arst_data",  {1'b0, data_o}, 33'h0);
    chk("arst_valid", {32'h0, data_valid_o}, 33'h0);
    chk("arst_last",  {32'h0, ch_last_o}, 33'h0);
    chk("arst_lvl",   {30'h0, fifo_lvl_o}, 33'h0);
    chk("arst_ovf",   {32'h0, overflow_o}, 33'h0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    tick();
    data_ready_i = 1'b1;
    update(2'd1, 1'b1);
    sb.push_back({1'b1, 32'h0CCC0BBB});
    send(16'h0BBB);
    send(16'h0CCC);
    chk("post_rst_word", {ch_last_o, data_o}, {1'b1, 32'h0CCC0BBB});
    repeat (3) tick();
    chk("post_rst_sb", 33'(sb.size()), 33'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
